// File: rtl/mcpu_ram_upload_if.sv
// rtl/mcpu_ram_upload_if.sv - ioctl upload request/response and byte-memory read port bundle
interface mcpu_ram_upload_if #(
  parameter int AW = 14
);
  logic          ioctl_upload;
  logic          ioctl_rd;
  logic [26:0]   ioctl_addr;
  logic [15:0]   ioctl_din;
  logic          ioctl_wait;
  logic          upload_done;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [7:0]    ram_q;

  // master is the environment side: hps_io requests plus the memory data return
  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, ram_q,
    input  ioctl_din, ioctl_wait, upload_done, ram_addr, ram_rd
  );

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, ram_q,
    output ioctl_din, ioctl_wait, upload_done, ram_addr, ram_rd
  );
endinterface

// File: rtl/mcpu_ram_upload.sv
// rtl/mcpu_ram_upload.sv - ioctl upload reader returning 16-bit little-endian words from byte memory
module mcpu_ram_upload #(
  parameter int          AW   = 14,
  parameter logic [26:0] BASE = 27'h0
) (
  input  logic            clk_sys,
  input  logic            reset,
  mcpu_ram_upload_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, CAP_HI} state_t;

  localparam logic [26:0]   LIMIT     = BASE + 27'(2**AW);
  localparam logic [AW-1:0] EVEN_MASK = {{(AW-1){1'b1}}, 1'b0};
  localparam logic [AW-1:0] ODD_BIT   = {{(AW-1){1'b0}}, 1'b1};

  state_t        state, next_state;
  logic          up_q;
  logic [AW-1:0] rel_r, rel_n;
  logic [7:0]    lo_r, lo_n;
  logic [15:0]   din_r, din_n;
  logic          wait_r, wait_n;
  logic [AW-1:0] addr_r, addr_n;
  logic          rd_r, rd_n;
  logic          done_r, done_n;

  logic          fall;
  logic          hit;
  logic [AW-1:0] rel_in;

  assign fall   = up_q & ~bus.ioctl_upload;
  assign hit    = (bus.ioctl_addr >= BASE) && (bus.ioctl_addr < LIMIT);
  // Low AW bits of the difference only depend on the low AW bits of the operands.
  assign rel_in = (bus.ioctl_addr[AW-1:0] - BASE[AW-1:0]) & EVEN_MASK;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state  <= IDLE;
      up_q   <= 1'b0;
      rel_r  <= '0;
      lo_r   <= 8'h00;
      din_r  <= 16'h0000;
      wait_r <= 1'b0;
      addr_r <= '0;
      rd_r   <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= next_state;
      up_q   <= bus.ioctl_upload;
      rel_r  <= rel_n;
      lo_r   <= lo_n;
      din_r  <= din_n;
      wait_r <= wait_n;
      addr_r <= addr_n;
      rd_r   <= rd_n;
      done_r <= done_n;
    end
  end

  always_comb begin
    next_state = state;
    if (fall) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.ioctl_upload && bus.ioctl_rd && hit) next_state = RD_LO;
        RD_LO:   next_state = RD_HI;
        RD_HI:   next_state = CAP_HI;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    rel_n  = rel_r;
    lo_n   = lo_r;
    din_n  = din_r;
    wait_n = wait_r;
    addr_n = addr_r;
    rd_n   = rd_r;
    done_n = fall;
    if (fall) begin
      wait_n = 1'b0;
      rd_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ioctl_upload && bus.ioctl_rd) begin
            if (hit) begin
              rel_n  = rel_in;
              addr_n = rel_in;
              rd_n   = 1'b1;
              wait_n = 1'b1;
            end else begin
              din_n = 16'hFFFF;
            end
          end
        end
        RD_LO:   addr_n = rel_r | ODD_BIT;
        RD_HI:   lo_n = bus.ram_q;
        default: begin
          din_n  = {bus.ram_q, lo_r};
          wait_n = 1'b0;
          rd_n   = 1'b0;
        end
      endcase
    end
  end

  assign bus.ioctl_din   = din_r;
  assign bus.ioctl_wait  = wait_r;
  assign bus.ram_addr    = addr_r;
  assign bus.ram_rd      = rd_r;
  assign bus.upload_done = done_r;
endmodule

// File: tb/tb_mcpu_ram_upload.sv
// tb/tb_mcpu_ram_upload.sv - bench for mcpu_ram_upload at BASE 0 and BASE 0x8000
module tb_mcpu_ram_upload;
  logic        clk = 1'b0;
  logic        reset;
  logic        upload;
  logic        rd;
  logic [26:0] addr;
  logic [7:0]  mem [0:16383];
  logic [7:0]  qa = 8'h00;
  logic [7:0]  qb = 8'h00;
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  mcpu_ram_upload_if #(.AW(14)) bus_a ();
  mcpu_ram_upload_if #(.AW(14)) bus_b ();

  assign bus_a.ioctl_upload = upload;
  assign bus_a.ioctl_rd     = rd;
  assign bus_a.ioctl_addr   = addr;
  assign bus_a.ram_q        = qa;
  assign bus_b.ioctl_upload = upload;
  assign bus_b.ioctl_rd     = rd;
  assign bus_b.ioctl_addr   = addr;
  assign bus_b.ram_q        = qb;

  // Synchronous-read byte memory shared by both instances.
  always @(posedge clk) begin
    qa <= mem[bus_a.ram_addr];
    qb <= mem[bus_b.ram_addr];
  end

  mcpu_ram_upload #(.AW(14), .BASE(27'h0)) dut_a (
    .clk_sys (clk),
    .reset   (reset),
    .bus     (bus_a)
  );

  mcpu_ram_upload #(.AW(14), .BASE(27'h8000)) dut_b (
    .clk_sys (clk),
    .reset   (reset),
    .bus     (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [15:0] model_word(input int rel);
    int e;
    e = rel & 'h3FFE;
    return {mem[e + 1], mem[e]};
  endfunction

  // One read request; expectations come from window arithmetic and the memory contents.
  task automatic do_read(input logic [26:0] a, input bit full);
    bit ha, hb;
    int ra, rb;
    ha = (a < 27'h4000);
    hb = (a >= 27'h8000) && (a < 27'hC000);
    ra = int'(a) & 'h3FFE;
    rb = int'(a - 27'h8000) & 'h3FFE;
    @(negedge clk);
    addr = a;
    rd   = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    chk("wait_t0_a", bus_a.ioctl_wait, ha);
    chk("wait_t0_b", bus_b.ioctl_wait, hb);
    if (!ha) chk("miss_din_a", bus_a.ioctl_din, 16'hFFFF);
    if (!hb) chk("miss_din_b", bus_b.ioctl_din, 16'hFFFF);
    if (full && ha) chk("addr_lo_a", bus_a.ram_addr, ra);
    if (full && hb) chk("addr_lo_b", bus_b.ram_addr, rb);
    if (ha || hb) begin
      @(negedge clk);
      if (full && ha) chk("addr_hi_a", bus_a.ram_addr, ra | 1);
      if (full && hb) chk("addr_hi_b", bus_b.ram_addr, rb | 1);
      @(negedge clk);
      if (full) begin
        chk("wait_t2_a", bus_a.ioctl_wait, ha);
        chk("wait_t2_b", bus_b.ioctl_wait, hb);
      end
      @(negedge clk);
      chk("wait_t3_a", bus_a.ioctl_wait, 0);
      chk("wait_t3_b", bus_b.ioctl_wait, 0);
      if (ha) chk("din_a", bus_a.ioctl_din, model_word(ra));
      if (hb) chk("din_b", bus_b.ioctl_din, model_word(rb));
      if (full) begin
        chk("ram_rd_end_a", bus_a.ram_rd, 0);
        chk("ram_rd_end_b", bus_b.ram_rd, 0);
      end
    end
  endtask

  initial begin
    logic [26:0] ra_addr;
    reset  = 1'b1;
    upload = 1'b0;
    rd     = 1'b0;
    addr   = 27'h0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'(i);

    repeat (2) @(negedge clk);
    chk("rst_din", bus_a.ioctl_din, 0);
    chk("rst_wait", bus_a.ioctl_wait, 0);
    chk("rst_ram_addr", bus_a.ram_addr, 0);
    chk("rst_ram_rd", bus_a.ram_rd, 0);
    chk("rst_done", bus_a.upload_done, 0);
    chk("rst_din_b", bus_b.ioctl_din, 0);
    reset  = 1'b0;
    upload = 1'b1;

    mem[0] = 8'h34;
    mem[1] = 8'h12;
    do_read(27'h0, 1'b1);
    chk("word_1234", bus_a.ioctl_din, 16'h1234);

    mem[2] = 8'hA5;
    mem[3] = 8'h5A;
    do_read(27'h8003, 1'b1);
    chk("odd_addr_b", bus_b.ioctl_din, 16'h5AA5);
    do_read(27'h7FFE, 1'b1);
    do_read(27'hC000, 1'b1);

    // Second ioctl_rd while the first fetch is in flight must be dropped.
    @(negedge clk);
    addr = 27'h40;
    rd   = 1'b1;
    @(negedge clk);
    addr = 27'h100;
    @(negedge clk);
    rd = 1'b0;
    chk("extra_addr_hi", bus_a.ram_addr, 27'h41);
    @(negedge clk);
    chk("extra_wait_t2", bus_a.ioctl_wait, 1);
    @(negedge clk);
    chk("extra_wait_t3", bus_a.ioctl_wait, 0);
    chk("extra_din", bus_a.ioctl_din, {mem[27'h41], mem[27'h40]});
    @(negedge clk);
    chk("extra_wait_t4", bus_a.ioctl_wait, 0);
    chk("extra_ram_rd_t4", bus_a.ram_rd, 0);
    chk("extra_addr_t4", bus_a.ram_addr, 27'h41);

    @(negedge clk);
    addr = 27'h80;
    rd   = 1'b1;
    @(negedge clk);
    rd     = 1'b0;
    upload = 1'b0;
    @(negedge clk);
    chk("drop_wait", bus_a.ioctl_wait, 0);
    chk("drop_ram_rd", bus_a.ram_rd, 0);
    chk("drop_done", bus_a.upload_done, 1);
    chk("drop_done_b", bus_b.upload_done, 1);
    chk("drop_din", bus_a.ioctl_din, {mem[27'h41], mem[27'h40]});
    @(negedge clk);
    chk("drop_done_pulse", bus_a.upload_done, 0);
    chk("drop_wait_t2", bus_a.ioctl_wait, 0);
    chk("drop_din_t2", bus_a.ioctl_din, {mem[27'h41], mem[27'h40]});
    upload = 1'b1;

    @(negedge clk);
    addr = 27'h10;
    rd   = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_din", bus_a.ioctl_din, 0);
    chk("midrst_wait", bus_a.ioctl_wait, 0);
    chk("midrst_ram_addr", bus_a.ram_addr, 0);
    chk("midrst_ram_rd", bus_a.ram_rd, 0);
    chk("midrst_done", bus_a.upload_done, 0);
    reset = 1'b0;
    do_read(27'h10, 1'b1);

    for (int i = 0; i < 16384; i++) mem[i] = 8'(i);
    for (int a = 0; a < 'h4000; a += 2) do_read(27'(a), 1'b0);
    chk("sweep_last", bus_a.ioctl_din, 16'hFFFE);

    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    for (int n = 0; n < 300; n++) begin
      ra_addr = 27'($urandom_range(0, 'hFFFF));
      if ($urandom_range(0, 9) == 0) ra_addr = 27'($urandom);
      do_read(ra_addr, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mcpu_ram_upload.md
# mcpu_ram_upload

Read-side counterpart of the main-CPU ROM/RAM download loaders: services MiSTer `ioctl` upload requests by reading a byte-wide, synchronous-read memory and returning 16-bit little-endian words to the HPS. It sits between `hps_io` and a spare read port of the target memory, for example the main-CPU work RAM used for NVRAM or high-score save. It stretches each request with `ioctl_wait` while it performs two sequential byte fetches.

## Interface
- `AW`, 14: memory address width; the upload window is 2^AW bytes.
- `BASE`, 27'h0: first `ioctl_addr` byte address mapped to memory address 0.
- `clk_sys`  in  1: system clock; all logic is on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `ioctl_upload`  in  1: high for the whole upload transfer.
- `ioctl_rd`  in  1: one-cycle word-read request.
- `ioctl_addr`  in  27: byte address of the request; bit 0 is ignored, so the address is forced even.
- `ioctl_din`  out  16: returned word, `{byte[a+1], byte[a]}`.
- `ioctl_wait`  out  1: high while a fetch is in progress.
- `ram_addr`  out  AW: registered memory read address.
- `ram_rd`  out  1: memory read strobe, high while a fetch is active.
- `ram_q`  in  8: memory data, valid one cycle after `ram_addr` is sampled.
- `upload_done`  out  1: one-cycle pulse on the falling edge of `ioctl_upload`.

## Operation
- States: IDLE, RD_LO, RD_HI, CAP_HI.
- Window hit: `ioctl_addr >= BASE && ioctl_addr < BASE + 2**AW`. Compare in 27 bits.
- Relative address: `rel = (ioctl_addr - BASE)[AW-1:0]` with bit 0 cleared.
- IDLE with `ioctl_upload && ioctl_rd`:
  - hit: latch `rel`; `ram_addr<=rel`; `ram_rd<=1`; `ioctl_wait<=1`; go to RD_LO.
  - miss: `ioctl_din<=16'hFFFF`; `ioctl_wait` stays 0; stay in IDLE.
- RD_LO: `ram_addr<=rel|1`; go to RD_HI.
- RD_HI: `lo<=ram_q`; go to CAP_HI.
- CAP_HI: `ioctl_din<={ram_q,lo}`; `ioctl_wait<=0`; `ram_rd<=0`; go to IDLE.
- `ioctl_rd` outside IDLE: ignored. The request is not queued.
- `ioctl_rd` while `ioctl_upload=0`: ignored.
- `ioctl_upload` falling in any state:
  - next state IDLE; `ioctl_wait<=0`; `ram_rd<=0`.
  - `ioctl_din` holds its last value.
  - `upload_done<=1` for exactly one cycle.
- Top byte of the window: `rel|1 = 2^AW-1`. No wrap is needed, because `rel` is even.
- The memory itself is never written by this block.

## Timing
- Reset values:
  - `ioctl_din=0`, `ioctl_wait=0`, `ram_addr=0`, `ram_rd=0`, `upload_done=0`.
  - state IDLE; internal edge register of `ioctl_upload` = 0.
- Hit request sampled at edge T0:
  - `ioctl_wait` is high after T0, T1 and T2, and low after T3.
  - `ioctl_din` is valid after T3, and the response latency is 4 edges.
- Miss request: `ioctl_din=FFFF` after T0, with no wait asserted.
- Back-to-back: a new `ioctl_rd` is accepted on the edge after T3, because the state is IDLE again.
- `reset` high at any edge: everything returns to reset values on that edge. `reset` has priority over all other inputs.

## Test plan
- Memory byte 0x0000=0x34, byte 0x0001=0x12; upload on; `ioctl_rd` with `ioctl_addr=0` → `ioctl_wait` high for 3 cycles, then `ioctl_din=16'h1234`; `ram_addr` sequence 0, 1.
- `BASE=27'h8000`, `AW=14`; read at 0x8003 → fetches 0x0002/0x0003 (bit 0 ignored); read at 0x7FFE and at 0xC000 → `ioctl_din=FFFF`, `ioctl_wait` never rises.
- Full-window sweep: bytes initialised to `addr[7:0]`; sequential reads at even addresses 0..0x3FFE → each `ioctl_din={a+1,a}`; the last word is `16'hFFFE`.
- Extra `ioctl_rd` pulse at T1 during a fetch → ignored; a single response; the state sequence is unchanged.
- `ioctl_upload` dropped at T1 → `ioctl_wait=0` and IDLE on the next edge; `upload_done` high for exactly 1 cycle; `ioctl_din` unchanged.
- `reset` asserted at T2 of a fetch → all outputs 0 after that edge; a following read completes normally.
